add_rr_scheduler: RTL and testbench

- Shares one add64CLA instance (N-bit carry-lookahead adder) between NREQ requesters.
- Uses round-robin arbitration and a valid/ready handshake on both the request and response sides.
- Registers the operands into the adder, captures sum and carry-out, and returns them tagged with the requester id.
- Sits between the client ports of the arithmetic subsystem and the shared CLA datapath. It also keeps a saturating count of carry-out events.

---
 rtl/add_rr_scheduler.sv | 166 ++++++++++++++++
 tb/tb_add_rr_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/add_rr_scheduler.sv
// Round-robin scheduler sharing one carry-lookahead adder between NREQ requesters.
// Each request is registered, added in a single CALC cycle, and returned with its requester id.

module add64CLA #(
    parameter int N = 64
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] S,
    output logic         carry_out
);
    localparam int NG = (N + 3) / 4;
    localparam int NP = NG * 4;

    logic [NP-1:0] ax, bx, g, p, sum_full;
    logic [NP:0]   c;
    logic [NG:0]   gc;

    // Operands are zero-padded to whole 4-bit groups; padded bits never generate or propagate.
    assign ax    = NP'(a);
    assign bx    = NP'(b);
    assign g     = ax & bx;
    assign p     = ax ^ bx;
    assign gc[0] = cin;

    for (genvar j = 0; j < NG; j++) begin : g_grp
        localparam int B = 4 * j;
        logic grp_g, grp_p;

        assign c[B]   = gc[j];
        assign c[B+1] = g[B] | (p[B] & gc[j]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[j]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & gc[j]);
        assign grp_g  = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p  = p[B+3] & p[B+2] & p[B+1] & p[B];
        assign gc[j+1] = grp_g | (grp_p & gc[j]);
    end

    assign c[NP]     = gc[NG];
    assign sum_full  = p ^ c[NP-1:0];
    assign S         = sum_full[N-1:0];
    assign carry_out = c[N];
endmodule

module add_rr_scheduler #(
    parameter int N    = 64,
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CW   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic [CW-1:0]     cout_count,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_r;
    logic [N-1:0]   a_r, b_r;
    logic           cin_r;

    logic           grant_found;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] cand;
    logic           accept;
    logic [N-1:0]   cla_sum;
    logic           cla_cout;

    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = rr_ptr + IDW'(i);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state == IDLE) && grant_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[grant_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    add64CLA #(.N(N)) u_cla (
        .a         (a_r),
        .b         (b_r),
        .cin       (cin_r),
        .S         (cla_sum),
        .carry_out (cla_cout)
    );

    // NOTE: operand and id registers carry no reset; they are only consumed after a load on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= req_a[grant_idx*N +: N];
            b_r   <= req_b[grant_idx*N +: N];
            cin_r <= req_cin[grant_idx];
            id_r  <= grant_idx;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            cout_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr <= grant_idx + IDW'(1);
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= cla_sum;
                    rsp_cout  <= cla_cout;
                    rsp_id    <= id_r;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_cout && (cout_count != {CW{1'b1}}))
                            cout_count <= cout_count + CW'(1);
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_add_rr_scheduler.sv
// Directed bench for add_rr_scheduler: handshake timing, arbitration order,
// backpressure, mid-operation reset and a batch of random adds against a native sum.

module tb_add_rr_scheduler;
    localparam int N    = 64;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CW   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_sum;
    logic              rsp_cout;
    logic [CW-1:0]     cout_count;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int exp_count   = 0;

    add_rr_scheduler #(.N(N), .NREQ(NREQ), .IDW(IDW), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .cout_count (cout_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int k, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
        req_a[k*N +: N] = a;
        req_b[k*N +: N] = b;
        req_cin[k]      = c;
    endtask

    // Entered in IDLE with rsp_ready=1; returns in IDLE after the response handshake.
    task automatic do_one(input int k, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic c, input string tag);
        logic [N:0]      full;
        logic [NREQ-1:0] onehot;
        full   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c};
        onehot = NREQ'(1) << k;
        load(k, a, b, c);
        req_valid = onehot;
        #1;
        check({tag, "_ready"}, req_ready, onehot);
        tick();
        req_valid = '0;
        #1;
        check({tag, "_calc_valid"}, rsp_valid, 1'b0);
        check({tag, "_calc_ready"}, req_ready, '0);
        check({tag, "_calc_busy"}, busy, 1'b1);
        tick();
        check({tag, "_valid"}, rsp_valid, 1'b1);
        check({tag, "_id"}, rsp_id, k[IDW-1:0]);
        check({tag, "_sum"}, rsp_sum, full[N-1:0]);
        check({tag, "_cout"}, rsp_cout, full[N]);
        tick();
        if (full[N]) exp_count++;
        check({tag, "_done_valid"}, rsp_valid, 1'b0);
        check({tag, "_count"}, cout_count, exp_count[CW-1:0]);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic         rc;
        int           rk;

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        req_valid = 4'b1111;
        #1;
        check("rst_ready_forced", req_ready, 4'b0000);
        rst       = 1'b0;
        req_valid = '0;
        check("rst_valid", rsp_valid, 1'b0);
        check("rst_id", rsp_id, 2'd0);
        check("rst_sum", rsp_sum, 64'd0);
        check("rst_cout", rsp_cout, 1'b0);
        check("rst_count", cout_count, 16'd0);
        check("rst_busy", busy, 1'b0);

        // Single requester, small operands with carry-in
        do_one(2, 64'd5, 64'd7, 1'b1, "t1");
        check("t1_sum13", rsp_sum, 64'd13);

        // Full-width overflow
        do_one(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, "t2");
        check("t2_count1", cout_count, 16'd1);

        // All requesters valid: grants 0,1,2,3,0 every third cycle
        for (int k = 0; k < NREQ; k++) load(k, 64'(k * 100 + 1), 64'(k), k[0]);
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            int k;
            k = i % NREQ;
            #1;
            check("t3_ready", req_ready, NREQ'(1) << k);
            tick();
            check("t3_calc_ready", req_ready, 4'b0000);
            check("t3_calc_valid", rsp_valid, 1'b0);
            tick();
            check("t3_resp_ready", req_ready, 4'b0000);
            check("t3_valid", rsp_valid, 1'b1);
            check("t3_id", rsp_id, k[IDW-1:0]);
            check("t3_sum", rsp_sum, 64'(k * 101 + 1 + (k % 2)));
            tick();
        end
        req_valid = '0;

        // Backpressure on requester 1 while requester 0 waits
        load(1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1;
        check("t4_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        #1;
        check("t4_calc_ready", req_ready, 4'b0000);
        tick();
        check("t4_valid", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", rsp_valid, 1'b1);
            check("t4_hold_id", rsp_id, 2'd1);
            check("t4_hold_sum", rsp_sum, 64'd2);
            check("t4_hold_cout", rsp_cout, 1'b1);
            check("t4_hold_ready", req_ready, 4'b0000);
        end
        rsp_ready = 1'b1;
        tick();
        exp_count++;
        check("t4_idle_valid", rsp_valid, 1'b0);
        check("t4_idle_busy", busy, 1'b0);
        check("t4_next_ready", req_ready, 4'b0001);
        check("t4_count", cout_count, 16'd2);
        check("t4_sum_kept", rsp_sum, 64'd2);
        tick();
        req_valid = '0;
        tick();
        check("t4_next_id", rsp_id, 2'd0);
        check("t4_next_sum", rsp_sum, 64'd1);
        tick();

        // Reset during CALC drops the operation and clears rr_ptr
        load(2, 64'd10, 64'd20, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t5_ready", req_ready, 4'b0100);
        tick();
        rst = 1'b1;
        #1;
        check("t5_calc_ready", req_ready, 4'b0000);
        tick();
        check("t5_rst_ready", req_ready, 4'b0000);
        check("t5_rst_valid", rsp_valid, 1'b0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        exp_count = 0;
        check("t5_valid", rsp_valid, 1'b0);
        check("t5_id", rsp_id, 2'd0);
        check("t5_sum", rsp_sum, 64'd0);
        check("t5_cout", rsp_cout, 1'b0);
        check("t5_count", cout_count, 16'd0);
        check("t5_busy", busy, 1'b0);
        tick();
        check("t5_no_rsp", rsp_valid, 1'b0);
        req_valid = 4'b1111;
        #1;
        check("t5_grant0", req_ready, 4'b0001);
        req_valid = '0;
        #1;

        // Random adds from random requesters
        for (int i = 0; i < 50; i++) begin
            rk = int'($urandom_range(0, NREQ - 1));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            rc = 1'($urandom_range(0, 1));
            do_one(rk, ra, rb, rc, "t6");
        end
        check("t6_final_count", cout_count, exp_count[CW-1:0]);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
